// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM signal bundle for sram_port_arbiter.
// master = pipeline ports plus SRAM macro side; slave = the arbiter.
interface sram_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  // Instruction-fetch port
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;

  // Data (load/store) port
  logic          d_req;
  logic [SW-1:0] d_wstrb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  // Single-port SRAM
  logic          sram_en;
  logic [SW-1:0] sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack,
    output d_req, d_wstrb, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack,
    input  d_req, d_wstrb, d_addr, d_wdata,
    output d_rdata, d_ack,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and load/store ports with alternating grants.
// Optional conflict counter enabled by defining SRAM_ARB_PERF_EN.
module sram_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_port_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [31:0]          perf_conflict_cnt
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state;
  state_t        nextState;

  logic          grant;
  logic          grantData;
  logic          ownerData;
  logic          lastGrantData;
  logic [AW-1:0] latAddr;
  logic [SW-1:0] latWstrb;
  logic [DW-1:0] latWdata;
  logic [1:0]    latCnt;
  logic          isWrite;
  logic          ackCycle;

  assign isWrite  = |latWstrb;
  assign ackCycle = (state == WAIT) && (latCnt == 2'd1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and arbitration: on conflict the port not granted last time wins
  always_comb begin
    nextState = state;
    grant     = 1'b0;
    grantData = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant     = 1'b1;
          grantData = bus.d_req && (!bus.i_req || !lastGrantData);
          nextState = ACCESS;
        end
      end
      ACCESS: nextState = WAIT;
      WAIT: begin
        if (latCnt == 2'd1) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture and latency countdown; fetch accesses never write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerData     <= 1'b0;
      lastGrantData <= 1'b0;
      latAddr       <= '0;
      latWstrb      <= '0;
      latWdata      <= '0;
      latCnt        <= 2'd0;
    end else begin
      if (grant) begin
        ownerData     <= grantData;
        lastGrantData <= grantData;
        latAddr       <= (grantData ? bus.d_addr : bus.i_addr) & ~AW'(3);
        latWstrb      <= grantData ? bus.d_wstrb : '0;
        latWdata      <= grantData ? bus.d_wdata : '0;
      end
      if (state == ACCESS) begin
        latCnt <= isWrite ? 2'd1 : 2'(RD_LAT);
      end else if (state == WAIT) begin
        latCnt <= latCnt - 2'd1;
      end
    end
  end

  // Output decode from registered state; read data passes through only in the ack cycle
  always_comb begin
    busy           = (state != IDLE);
    bus.sram_en    = 1'b0;
    bus.sram_wen   = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.i_ack      = 1'b0;
    bus.d_ack      = 1'b0;
    bus.i_rdata    = '0;
    bus.d_rdata    = '0;
    if (state == ACCESS) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = latWstrb;
      bus.sram_addr  = latAddr;
      bus.sram_wdata = latWdata;
    end
    if (ackCycle) begin
      if (ownerData) begin
        bus.d_ack = 1'b1;
        if (!isWrite) begin
          bus.d_rdata = bus.sram_rdata;
        end
      end else begin
        bus.i_ack   = 1'b1;
        bus.i_rdata = bus.sram_rdata;
      end
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] conflictCnt;

  // Saturating count of IDLE cycles with both ports requesting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflictCnt <= 32'd0;
    end else if ((state == IDLE) && bus.i_req && bus.d_req && (conflictCnt != 32'hFFFF_FFFF)) begin
      conflictCnt <= conflictCnt + 32'd1;
    end
  end

  assign perf_conflict_cnt = conflictCnt;
`else
  assign perf_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        busy1;
  logic        busy3;
  logic [31:0] perf1;
  logic [31:0] perf3;
  int          nVec;
  int          nMis;

  sram_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
  sram_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

  sram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1), .perf_conflict_cnt(perf1)
  );

  sram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave), .busy(busy3), .perf_conflict_cnt(perf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_wstrb = '0;
    b1.d_addr = '0;  b1.d_wdata = '0; b1.sram_rdata = '0;
    b3.i_req = 1'b0; b3.i_addr = '0; b3.d_req = 1'b0; b3.d_wstrb = '0;
    b3.d_addr = '0;  b3.d_wdata = '0; b3.sram_rdata = '0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    rst  = 1'b0;
    clearInputs();
    step();
    step();
    rst = 1'b1;

    // Reset mid-WAIT on the RD_LAT=3 instance: everything zero, access abandoned
    b3.d_req = 1'b1; b3.d_addr = 32'h0000_0100; b3.sram_rdata = 32'hDEAD_BEEF;
    step(); step(); step();
    check("mid_wait_busy", busy3, 1);
    rst = 1'b0;
    b3.d_req = 1'b0;
    #1;
    check("rst_busy", busy3, 0);
    check("rst_sram_en", b3.sram_en, 0);
    check("rst_sram_addr", b3.sram_addr, 0);
    check("rst_d_ack", b3.d_ack, 0);
    check("rst_i_ack", b3.i_ack, 0);
    check("rst_d_rdata", b3.d_rdata, 0);
    check("rst_perf", perf3, 0);
    check("rst_busy1", busy1, 0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("abandon_no_ack", b3.d_ack, 0);
    end

    // Fetch read at RD_LAT=1
    b1.i_req = 1'b1; b1.i_addr = 32'hBFC0_0003; b1.sram_rdata = 32'h1357_9BDF;
    step();
    check("rd_sram_en", b1.sram_en, 1);
    check("rd_sram_addr", b1.sram_addr, 32'hBFC0_0000);
    check("rd_sram_wen", b1.sram_wen, 0);
    check("rd_i_ack_c1", b1.i_ack, 0);
    step();
    check("rd_i_ack", b1.i_ack, 1);
    check("rd_i_rdata", b1.i_rdata, 32'h1357_9BDF);
    check("rd_d_rdata", b1.d_rdata, 0);
    b1.i_req = 1'b0;
    step();
    check("rd_idle_busy", busy1, 0);

    // Data write
    b1.d_req = 1'b1; b1.d_wstrb = 4'b0011; b1.d_addr = 32'h8000_0010; b1.d_wdata = 32'h1234_5678;
    step();
    check("wr_sram_en", b1.sram_en, 1);
    check("wr_sram_wen", b1.sram_wen, 4'b0011);
    check("wr_sram_wdata", b1.sram_wdata, 32'h1234_5678);
    check("wr_sram_addr", b1.sram_addr, 32'h8000_0010);
    check("wr_i_ack_c1", b1.i_ack, 0);
    step();
    check("wr_d_ack", b1.d_ack, 1);
    check("wr_i_ack_c2", b1.i_ack, 0);
    b1.d_req = 1'b0; b1.d_wstrb = '0;
    step();
    check("wr_idle_busy", busy1, 0);

    // Simultaneous first requests after reset: D first
    doReset();
    b1.d_req = 1'b1; b1.d_addr = 32'h0000_0100;
    b1.i_req = 1'b1; b1.i_addr = 32'h0000_0200;
    b1.sram_rdata = 32'h0BAD_F00D;
    step();
    check("sim_c1_addr", b1.sram_addr, 32'h0000_0100);
    step();
    check("sim_c2_d_ack", b1.d_ack, 1);
    check("sim_c2_i_ack", b1.i_ack, 0);
    check("sim_c2_d_rdata", b1.d_rdata, 32'h0BAD_F00D);
    b1.d_req = 1'b0;
    step();
    check("sim_c3_busy", busy1, 0);
    step();
    check("sim_c4_addr", b1.sram_addr, 32'h0000_0200);
    step();
    check("sim_c5_i_ack", b1.i_ack, 1);
    b1.i_req = 1'b0;
    step();
    check("sim_perf", perf1, PERF ? 32'd1 : 32'd0);

    // Both held continuously: acks d,i,d,i at cycles 2,5,8,11
    b1.d_req = 1'b1; b1.i_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      check($sformatf("alt_d_ack_c%0d", c), b1.d_ack, (c == 2 || c == 8) ? 1 : 0);
      check($sformatf("alt_i_ack_c%0d", c), b1.i_ack, (c == 5 || c == 11) ? 1 : 0);
    end
    b1.d_req = 1'b0; b1.i_req = 1'b0;
    step();
    check("alt_idle_busy", busy1, 0);
    check("alt_perf", perf1, PERF ? 32'd5 : 32'd0);

    // RD_LAT=3 data read
    b3.d_req = 1'b1; b3.d_addr = 32'h0000_0040; b3.sram_rdata = 32'hA5A5_0F0F;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("lat3_d_ack_c%0d", c), b3.d_ack, (c == 4) ? 1 : 0);
      check($sformatf("lat3_d_rdata_c%0d", c), b3.d_rdata, (c == 4) ? 32'hA5A5_0F0F : 32'd0);
      if (c == 4) b3.d_req = 1'b0;
    end
    check("lat3_idle_busy", busy3, 0);

    // Owner drops i_req during WAIT: ack still pulses once
    b3.i_req = 1'b1; b3.i_addr = 32'h0000_0008; b3.sram_rdata = 32'h5555_AAAA;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) b3.i_req = 1'b0;
      check($sformatf("drop_i_ack_c%0d", c), b3.i_ack, (c == 4) ? 1 : 0);
    end
    check("drop_busy", busy3, 0);
    check("drop_sram_en", b3.sram_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
